input_vc_controller: RTL

Per-virtual-channel controller inside the router input block. It buffers incoming flits for one upstream VC and computes the XY output port from each head flit. It drives the VC-allocation request and output port consumed by the VC allocator, captures the granted downstream VC, then issues (speculative) switch requests and forwards flits tagged with the new VC id. One instance exists per (input port, VC); VC_TOTAL instances feed the allocators through the input-block interface.

---
 rtl/input_vc_controller_pkg.sv | 70 +++++++
 rtl/input_vc_controller_buffer.sv | 79 +++++++
 rtl/input_vc_controller.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/input_vc_controller_pkg.sv
// Shared NoC types for the router input block: flit format, output ports,
// controller states and the XY routing helpers.
package noc_params;

    localparam int VC_NUM           = 2;
    localparam int VC_SIZE          = $clog2(VC_NUM);
    localparam int MESH_SIZE_X      = 4;
    localparam int MESH_SIZE_Y      = 4;
    localparam int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X);
    localparam int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y);
    localparam int FLIT_DATA_SIZE   = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_t;

    typedef struct packed {
        flit_label_t                 label;
        logic [VC_SIZE-1:0]          vc_id;
        logic [DEST_ADDR_SIZE_X-1:0] dest_x;
        logic [DEST_ADDR_SIZE_Y-1:0] dest_y;
        logic [FLIT_DATA_SIZE-1:0]   data;
    } flit_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VA     = 2'd1,
        ACTIVE = 2'd2
    } ctrl_state_t;

    function automatic logic is_head(input flit_label_t label);
        return (label == HEAD) || (label == HEADTAIL);
    endfunction

    function automatic logic is_tail(input flit_label_t label);
        return (label == TAIL) || (label == HEADTAIL);
    endfunction

    // X is resolved first, so packets never turn from a Y hop back into X.
    function automatic port_t xy_route(input logic [DEST_ADDR_SIZE_X-1:0] dest_x,
                                       input logic [DEST_ADDR_SIZE_Y-1:0] dest_y,
                                       input int x_cur,
                                       input int y_cur);
        port_t port_v;
        if (int'(dest_x) > x_cur) begin
            port_v = EAST;
        end else if (int'(dest_x) < x_cur) begin
            port_v = WEST;
        end else if (int'(dest_y) > y_cur) begin
            port_v = SOUTH;
        end else if (int'(dest_y) < y_cur) begin
            port_v = NORTH;
        end else begin
            port_v = LOCAL;
        end
        return port_v;
    endfunction

endpackage

// File: rtl/input_vc_controller_buffer.sv
// Circular flit FIFO for one input VC; a write into a full buffer is dropped
// even when a pop happens in the same cycle.
import noc_params::*;

module circular_flit_buffer #(
    parameter int BUFFER_SIZE = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  write_i,
    input  logic  read_i,
    input  flit_t flit_i,
    output flit_t flit_o,
    output logic  is_full_o,
    output logic  is_empty_o
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_SIZE);

    flit_t            mem_r [BUFFER_SIZE];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             full_r;
    logic             empty_r;
    logic             do_write_s;
    logic             do_read_s;

    assign do_write_s = write_i & ~full_r;
    assign do_read_s  = read_i & ~empty_r;

    // Next occupancy from the accepted write/read pair
    always_comb begin
        count_next_s = count_r;
        case ({do_write_s, do_read_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, occupancy and registered full/empty flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_write_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_read_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == CNT_FULL);
            empty_r <= (count_next_s == '0);
        end
    end

    // Flit storage; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (do_write_s) begin
            mem_r[wr_ptr_r] <= flit_i;
        end
    end

    assign flit_o     = mem_r[rd_ptr_r];
    assign is_full_o  = full_r;
    assign is_empty_o = empty_r;

endmodule

// File: rtl/input_vc_controller.sv
// Per-VC input controller: buffers flits, XY-routes the head, requests a
// downstream VC and forwards flits (speculatively during VA) with the new vc_id.
import noc_params::*;

module input_vc_controller #(
    parameter int BUFFER_SIZE = 8,
    parameter int X_CURRENT   = 0,
    parameter int Y_CURRENT   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  flit_t              flit_i,
    input  logic               write_i,
    output logic               vc_request_o,
    output port_t              out_port_o,
    input  logic [VC_SIZE-1:0] vc_new_i,
    input  logic               vc_valid_i,
    output logic               switch_request_o,
    input  logic               sa_grant_i,
    output flit_t              flit_o,
    output logic               is_full_o,
    output logic               is_empty_o,
    output logic               error_o
);

    ctrl_state_t        state_r;
    port_t              out_port_r;
    logic [VC_SIZE-1:0] downstream_vc_r;
    logic               vc_request_r;
    logic               error_r;

    flit_t              front_s;
    logic               empty_s;
    logic               full_s;
    logic               pop_s;
    logic               discard_s;
    logic               grant_empty_s;
    logic               error_s;

    circular_flit_buffer #(
        .BUFFER_SIZE (BUFFER_SIZE)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .write_i    (write_i),
        .read_i     (pop_s),
        .flit_i     (flit_i),
        .flit_o     (front_s),
        .is_full_o  (full_s),
        .is_empty_o (empty_s)
    );

    // Pop decision and protocol-violation detection for the current cycle
    always_comb begin
        pop_s         = 1'b0;
        discard_s     = 1'b0;
        grant_empty_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s && !is_head(front_s.label)) begin
                    discard_s = 1'b1;
                    pop_s     = 1'b1;
                end else begin
                    discard_s = 1'b0;
                    pop_s     = 1'b0;
                end
                grant_empty_s = sa_grant_i & empty_s;
            end
            VA: begin
                // A grant without a VC in hand is not usable and is ignored
                if (sa_grant_i && vc_valid_i) begin
                    pop_s         = ~empty_s;
                    grant_empty_s = empty_s;
                end else begin
                    pop_s         = 1'b0;
                    grant_empty_s = 1'b0;
                end
            end
            ACTIVE: begin
                if (sa_grant_i) begin
                    pop_s         = ~empty_s;
                    grant_empty_s = empty_s;
                end else begin
                    pop_s         = 1'b0;
                    grant_empty_s = 1'b0;
                end
            end
            default: begin
                pop_s         = 1'b0;
                discard_s     = 1'b0;
                grant_empty_s = 1'b0;
            end
        endcase
        error_s = discard_s | grant_empty_s | (write_i & full_s);
    end

    // Controller FSM with registered route, downstream VC, request and error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= IDLE;
            out_port_r      <= LOCAL;
            downstream_vc_r <= '0;
            vc_request_r    <= 1'b0;
            error_r         <= 1'b0;
        end else begin
            error_r <= error_s;
            case (state_r)
                IDLE: begin
                    if (!empty_s && is_head(front_s.label)) begin
                        out_port_r   <= xy_route(front_s.dest_x, front_s.dest_y,
                                                 X_CURRENT, Y_CURRENT);
                        state_r      <= VA;
                        vc_request_r <= 1'b1;
                    end else begin
                        state_r      <= IDLE;
                        vc_request_r <= 1'b0;
                    end
                end
                VA: begin
                    if (vc_valid_i) begin
                        downstream_vc_r <= vc_new_i;
                        vc_request_r    <= 1'b0;
                        if (pop_s && is_tail(front_s.label)) begin
                            state_r <= IDLE;
                        end else begin
                            state_r <= ACTIVE;
                        end
                    end else begin
                        state_r      <= VA;
                        vc_request_r <= 1'b1;
                    end
                end
                ACTIVE: begin
                    vc_request_r <= 1'b0;
                    if (pop_s && is_tail(front_s.label)) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= ACTIVE;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    vc_request_r <= 1'b0;
                end
            endcase
        end
    end

    // Outgoing flit carries the downstream VC; during VA that is the one being granted now
    always_comb begin
        flit_o = front_s;
        if (state_r == VA) begin
            flit_o.vc_id = vc_new_i;
        end else begin
            flit_o.vc_id = downstream_vc_r;
        end
    end

    assign switch_request_o = ((state_r == VA) || (state_r == ACTIVE)) & ~empty_s;
    assign vc_request_o     = vc_request_r;
    assign out_port_o       = out_port_r;
    assign is_full_o        = full_s;
    assign is_empty_o       = empty_s;
    assign error_o          = error_r;

endmodule
